// File: rtl/radiant_event_sched_pkg.sv
// ----------------------------------------------------------------------------
// radiant_event_sched_pkg
// Shared definitions for the event scheduler:
//   - default NUM_SRC / DEPTH values
//   - scheduler FSM state encoding
//   - bit offsets of the fields inside the 32-bit event info word
//   - pack_info(): assembles an info word from its fields
// ----------------------------------------------------------------------------
package radiant_event_sched_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int DEPTH_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    // Info word layout: {seq[15:0], pending mask[7:0], one-hot grant[7:0]}
    localparam int INFO_GNT_LSB  = 0;
    localparam int INFO_MASK_LSB = 8;
    localparam int INFO_SEQ_LSB  = 16;

    function automatic logic [31:0] pack_info(input logic [15:0] seq,
                                              input logic [7:0]  mask,
                                              input logic [7:0]  gnt);
        logic [31:0] w;
        w = '0;
        w[INFO_SEQ_LSB  +: 16] = seq;
        w[INFO_MASK_LSB +: 8]  = mask;
        w[INFO_GNT_LSB  +: 8]  = gnt;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Scans the request mask starting at
// ptr_i and wrapping, and grants the first requester found.
// Ports:
//   req_i   [N-1:0]  request mask
//   ptr_i   [PW-1:0] index to start the search at (one past last grant)
//   gnt_o   [N-1:0]  one-hot grant
//   idx_o   [PW-1:0] index of the granted requester
//   valid_o          a grant was made (req_i non-zero)
// ----------------------------------------------------------------------------
module rr_arbiter
    import radiant_event_sched_pkg::*;
#(
    parameter int N  = NUM_SRC_DEF,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        logic [PW:0] cand;
        logic        found;
        cand    = '0;
        found   = 1'b0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            // Candidate index (ptr_i + i) mod N, one extra bit for the carry.
            cand = {1'b0, ptr_i} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!found && req_i[cand[PW-1:0]]) begin
                found               = 1'b1;
                valid_o             = 1'b1;
                gnt_o[cand[PW-1:0]] = 1'b1;
                idx_o               = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/radiant_event_sched.sv
// ----------------------------------------------------------------------------
// radiant_event_sched
// Trigger-to-event scheduler protecting a DEPTH-entry event header FIFO.
// Trigger pulses are latched per source, granted round-robin, and issued as
// a one-cycle event strobe followed by a programmable deadtime.
//
// Optional build macro: RADIANT_EVENT_SCHED_FORCE_EN adds force_i, a pulse
// that requests a forced event (grant field 0) with priority over sources,
// ignoring enable_i, blocked only by full_o.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   enable_i              trigger acceptance enable (checked only in IDLE)
//   holdoff_i[15:0]       deadtime cycles after an event (sampled leaving ISSUE)
//   trig_i[NUM_SRC-1:0]   per-source trigger pulses
//   force_i               (FORCE_EN builds only) forced event request pulse
//   event_o               one-cycle event strobe
//   event_info_o[31:0]    {seq, pending mask, one-hot grant}; zero when idle
//   event_done_i          one header consumed by readout
//   occupancy_o[4:0]      outstanding unread events
//   full_o                occupancy_o == DEPTH
//   busy_o                FSM not in IDLE
//   dropped_o[15:0]       saturating count of triggers lost to a set pending bit
//   underflow_o           sticky: event_done_i seen with nothing outstanding
//
// Event/readout handshake: every event_o cycle produces one header; each
// event_done_i pulse retires one header. event_o is never raised while
// full_o is high, so occupancy never exceeds DEPTH. A done pulse at zero
// occupancy (without a same-cycle event_o) is discarded and flagged.
// ----------------------------------------------------------------------------
module radiant_event_sched
    import radiant_event_sched_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    input  logic [15:0]        holdoff_i,
    input  logic [NUM_SRC-1:0] trig_i,
`ifdef RADIANT_EVENT_SCHED_FORCE_EN
    input  logic               force_i,
`endif
    output logic               event_o,
    output logic [31:0]        event_info_o,
    input  logic               event_done_i,
    output logic [4:0]         occupancy_o,
    output logic               full_o,
    output logic               busy_o,
    output logic [15:0]        dropped_o,
    output logic               underflow_o
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [7:0]         mask_q, mask_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [15:0]        hold_q, hold_d;
    logic [15:0]        seq_q, seq_d;
    logic [4:0]         occ_q, occ_d;
    logic [15:0]        dropped_q, dropped_d;
    logic               underflow_q, underflow_d;
`ifdef RADIANT_EVENT_SCHED_FORCE_EN
    logic               force_q, force_d, force_take;
`endif

    logic [NUM_SRC-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic               arb_valid;
    logic [NUM_SRC-1:0] clr_mask;
    logic [3:0]         drop_n;
    logic [16:0]        drop_sum;

    rr_arbiter #(.N(NUM_SRC), .PW(PW)) u_rr_arbiter (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign event_o      = (state_q == ISSUE);
    assign event_info_o = event_o ? pack_info(seq_q, mask_q, 8'(grant_q)) : 32'd0;
    assign busy_o       = (state_q != IDLE);
    assign full_o       = (occ_q == 5'(DEPTH));
    assign occupancy_o  = occ_q;
    assign dropped_o    = dropped_q;
    assign underflow_o  = underflow_q;

    // FSM next state and grant capture
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        mask_d   = mask_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        clr_mask = '0;
`ifdef RADIANT_EVENT_SCHED_FORCE_EN
        force_take = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!full_o) begin
`ifdef RADIANT_EVENT_SCHED_FORCE_EN
                    if (force_q) begin
                        state_d    = ISSUE;
                        grant_d    = '0;
                        mask_d     = 8'(pending_q);
                        force_take = 1'b1;
                    end else if (enable_i && arb_valid) begin
                        state_d = ISSUE;
                        grant_d = arb_gnt;
                        mask_d  = 8'(pending_q);
                        ptr_d   = (arb_idx == PW'(NUM_SRC - 1)) ? '0 : arb_idx + 1'b1;
                    end
`else
                    if (enable_i && arb_valid) begin
                        state_d = ISSUE;
                        grant_d = arb_gnt;
                        mask_d  = 8'(pending_q);
                        ptr_d   = (arb_idx == PW'(NUM_SRC - 1)) ? '0 : arb_idx + 1'b1;
                    end
`endif
                end
            end
            ISSUE: begin
                clr_mask = grant_q;
                // HOLDOFF lasts exactly holdoff_i cycles; zero skips it.
                if (holdoff_i == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLDOFF;
                    hold_d  = holdoff_i - 16'd1;
                end
            end
            HOLDOFF: begin
                if (hold_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending bits, drop counter, sequence and occupancy bookkeeping
    always_comb begin
        // A trigger on an already-pending source is lost and counted.
        drop_n = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_n = drop_n + 4'(trig_i[i] & pending_q[i]);
        end
        drop_sum  = {1'b0, dropped_q} + 17'(drop_n);
        dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        pending_d = (pending_q & ~clr_mask) | trig_i;
        seq_d     = event_o ? seq_q + 16'd1 : seq_q;

        occ_d       = occ_q;
        underflow_d = underflow_q;
        unique case ({event_o, event_done_i})
            2'b10: occ_d = occ_q + 5'd1;
            2'b01: begin
                if (occ_q == 5'd0) begin
                    underflow_d = 1'b1;
                end else begin
                    occ_d = occ_q - 5'd1;
                end
            end
            default: occ_d = occ_q;
        endcase

`ifdef RADIANT_EVENT_SCHED_FORCE_EN
        force_d = (force_q & ~force_take) | force_i;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            grant_q     <= '0;
            mask_q      <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
            seq_q       <= '0;
            occ_q       <= '0;
            dropped_q   <= '0;
            underflow_q <= 1'b0;
`ifdef RADIANT_EVENT_SCHED_FORCE_EN
            force_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            grant_q     <= grant_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            seq_q       <= seq_d;
            occ_q       <= occ_d;
            dropped_q   <= dropped_d;
            underflow_q <= underflow_d;
`ifdef RADIANT_EVENT_SCHED_FORCE_EN
            force_q     <= force_d;
`endif
        end
    end

endmodule

// File: tb/tb_radiant_event_sched.sv
// ----------------------------------------------------------------------------
// tb_radiant_event_sched
// Self-checking bench for radiant_event_sched (default build, NUM_SRC=4,
// DEPTH=16). Inputs are driven just after the falling edge, outputs sampled
// on the falling edge. Expected info words are queued when triggers are
// driven and popped whenever event_o is observed.
// ----------------------------------------------------------------------------
module tb_radiant_event_sched;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic [15:0] holdoff = 16'd0;
  logic [3:0]  trig = 4'd0;
  logic        done = 1'b0;
  logic        event_o;
  logic [31:0] event_info_o;
  logic [4:0]  occupancy_o;
  logic        full_o;
  logic        busy_o;
  logic [15:0] dropped_o;
  logic        underflow_o;

  radiant_event_sched #(.NUM_SRC(4), .DEPTH(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .holdoff_i    (holdoff),
    .trig_i       (trig),
    .event_o      (event_o),
    .event_info_o (event_info_o),
    .event_done_i (done),
    .occupancy_o  (occupancy_o),
    .full_o       (full_o),
    .busy_o       (busy_o),
    .dropped_o    (dropped_o),
    .underflow_o  (underflow_o)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_cnt = 0;
  int last_ev_cyc = 0;
  int trig_cyc = 0;
  int base = 0;
  int exp_occ = 0;
  int ev_at[4];
  logic [15:0] exp_seq = 16'd0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  trig;
    logic [15:0] hold;
    int          exp_busy;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; scoreboard compare on every observed event.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    if (event_o === 1'b1) begin
      ev_cnt++;
      last_ev_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event got=%h exp=none (cycle %0d)", event_info_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_info", event_info_o, e);
      end
    end else begin
      chk("info_zero_when_idle", event_info_o, 32'd0);
    end
    #1;
  endtask

  task automatic expect_ev(input logic [3:0] mask, input logic [3:0] gnt);
    exp_q.push_back({exp_seq, 4'h0, mask, 4'h0, gnt});
    exp_seq++;
  endtask

  task automatic pulse_trig(input logic [3:0] t);
    trig = t;
    trig_cyc = cyc;
    tick();
    trig = 4'd0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_ev(input string name, input int budget);
    int target = ev_cnt + 1;
    int n = 0;
    while (ev_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (ev_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s no event_o within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_seq = 16'd0;
    exp_q.delete();
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_event"}, 32'(event_o), 32'd0);
    chk({tag, "_info"}, event_info_o, 32'd0);
    chk({tag, "_occ"}, 32'(occupancy_o), 32'd0);
    chk({tag, "_full"}, 32'(full_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_dropped"}, 32'(dropped_o), 32'd0);
    chk({tag, "_underflow"}, 32'(underflow_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] t;

    vecs[0] = '{4'b0010, 16'd0, 0};
    vecs[1] = '{4'b0100, 16'd1, 1};
    vecs[2] = '{4'b1000, 16'd5, 5};
    vecs[3] = '{4'b0001, 16'd2, 2};
    vecs[4] = '{4'b0100, 16'd0, 0};

    // reset state
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // single trigger, holdoff 0
    enable = 1'b1;
    holdoff = 16'd0;
    exp_q.push_back(32'h0000_0101);
    exp_seq++;
    pulse_trig(4'b0001);
    wait_ev("first_event", 10);
    chk("first_latency", 32'(last_ev_cyc - trig_cyc), 32'd2);
    tick();
    chk("first_occ", 32'(occupancy_o), 32'd1);
    exp_occ = 1;

    // table of single-source triggers with various holdoffs
    for (int i = 0; i < 5; i++) begin
      holdoff = vecs[i].hold;
      expect_ev(vecs[i].trig, vecs[i].trig);
      pulse_trig(vecs[i].trig);
      wait_ev("vec_event", 10);
      chk("vec_latency", 32'(last_ev_cyc - trig_cyc), 32'd2);
      n = 0;
      tick();
      while (busy_o && n < 100) begin
        n++;
        tick();
      end
      chk("vec_holdoff_len", 32'(n), 32'(vecs[i].exp_busy));
      exp_occ++;
      chk("vec_occ", 32'(occupancy_o), 32'(exp_occ));
    end
    pulse_done();
    chk("done_decrement", 32'(occupancy_o), 32'(exp_occ - 1));

    // all four sources at once, holdoff 3: grants 0,1,2,3 five cycles apart
    do_reset();
    holdoff = 16'd3;
    expect_ev(4'b1111, 4'b0001);
    expect_ev(4'b1110, 4'b0010);
    expect_ev(4'b1100, 4'b0100);
    expect_ev(4'b1000, 4'b1000);
    pulse_trig(4'b1111);
    for (int k = 0; k < 4; k++) begin
      wait_ev("rr_event", 20);
      ev_at[k] = last_ev_cyc;
    end
    chk("rr_latency", 32'(ev_at[0] - trig_cyc), 32'd2);
    for (int k = 1; k < 4; k++) chk("rr_spacing", 32'(ev_at[k] - ev_at[k-1]), 32'd5);
    repeat (6) tick();
    chk("rr_occ", 32'(occupancy_o), 32'd4);
    chk("rr_idle", 32'(busy_o), 32'd0);

    // fill to DEPTH, 17th trigger waits for a done
    do_reset();
    holdoff = 16'd0;
    for (int i = 0; i < 16; i++) begin
      t = 4'b0001 << (i % 4);
      expect_ev(t, t);
      pulse_trig(t);
      wait_ev("fill_event", 10);
      tick();
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_occ", 32'(occupancy_o), 32'd16);
    base = ev_cnt;
    expect_ev(4'b0001, 4'b0001);
    pulse_trig(4'b0001);
    repeat (10) tick();
    chk("full_blocks_event", 32'(ev_cnt - base), 32'd0);
    chk("full_not_busy", 32'(busy_o), 32'd0);
    chk("full_no_drop", 32'(dropped_o), 32'd0);
    pulse_done();
    wait_ev("after_done_event", 10);
    tick();
    chk("refill_occ", 32'(occupancy_o), 32'd16);
    chk("refill_full", 32'(full_o), 32'd1);

    // triggers while disabled
    do_reset();
    enable = 1'b0;
    base = ev_cnt;
    pulse_trig(4'b0100);
    tick();
    pulse_trig(4'b0100);
    repeat (3) tick();
    chk("disabled_dropped", 32'(dropped_o), 32'd1);
    chk("disabled_no_event", 32'(ev_cnt - base), 32'd0);
    chk("disabled_idle", 32'(busy_o), 32'd0);
    expect_ev(4'b0100, 4'b0100);
    enable = 1'b1;
    wait_ev("enable_event", 10);
    repeat (5) tick();
    chk("enable_one_event", 32'(ev_cnt - base), 32'd1);
    enable = 1'b0;
    pulse_trig(4'b0011);
    pulse_trig(4'b0011);
    chk("two_src_dropped", 32'(dropped_o), 32'd3);
    // pointer sits at 3 after granting source 2, so 0 wins before 1
    expect_ev(4'b0011, 4'b0001);
    expect_ev(4'b0010, 4'b0010);
    enable = 1'b1;
    wait_ev("wrap_event0", 10);
    wait_ev("wrap_event1", 10);
    repeat (3) tick();
    chk("wrap_occ", 32'(occupancy_o), 32'd3);

    // occupancy corner cases
    do_reset();
    enable = 1'b1;
    holdoff = 16'd0;
    expect_ev(4'b0001, 4'b0001);
    pulse_trig(4'b0001);
    wait_ev("done_same_cycle_event", 10);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("event_and_done_occ", 32'(occupancy_o), 32'd0);
    chk("event_and_done_no_uflow", 32'(underflow_o), 32'd0);
    pulse_done();
    chk("uflow_occ", 32'(occupancy_o), 32'd0);
    chk("uflow_set", 32'(underflow_o), 32'd1);
    expect_ev(4'b0010, 4'b0010);
    pulse_trig(4'b0010);
    wait_ev("post_uflow_event", 10);
    tick();
    chk("post_uflow_occ", 32'(occupancy_o), 32'd1);
    pulse_done();
    chk("post_uflow_dec", 32'(occupancy_o), 32'd0);
    chk("uflow_sticky", 32'(underflow_o), 32'd1);

    // asynchronous reset during HOLDOFF with occupancy 5
    do_reset();
    enable = 1'b1;
    holdoff = 16'd0;
    for (int i = 0; i < 4; i++) begin
      t = 4'b0001 << i;
      expect_ev(t, t);
      pulse_trig(t);
      wait_ev("pre_reset_event", 10);
      tick();
    end
    holdoff = 16'd200;
    expect_ev(4'b0001, 4'b0001);
    pulse_trig(4'b0001);
    wait_ev("holdoff_event", 10);
    repeat (3) tick();
    chk("holdoff_busy", 32'(busy_o), 32'd1);
    chk("holdoff_occ", 32'(occupancy_o), 32'd5);
    pulse_trig(4'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    base = ev_cnt;
    repeat (20) tick();
    chk("no_event_after_reset", 32'(ev_cnt - base), 32'd0);
    chk("idle_after_reset", 32'(busy_o), 32'd0);
    chk("sb_empty_end", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
